regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources:
//  r0 = EX/ALU writeback (normal priority) and r1 = load/multi-cycle return.
//  r1 requests are queued in a small FIFO; an aging counter guarantees r1 forward progress.
//  Drives the register file's per-register enables plus write data.
//  Exports a busy mask of destinations still queued, for the hazard unit.
// PARAMETERS
//  DEPTH     4   r1 queue entries (power of 2, >=2)
//  MAX_WAIT  3   cycles a non-empty queue head may lose arbitration before it is forced to win
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low; clears all state
//  r0_valid    in   1       EX writeback request
//  r0_ready    out  1       EX request accepted when r0_valid & r0_ready at clk edge
//  r0_addr     in   5       destination register
//  r0_data     in   64      write data
//  r1_valid    in   1       load writeback request
//  r1_ready    out  1       queue can accept (= !full)
//  r1_addr     in   5       destination register
//  r1_data     in   64      write data
//  wr_enables  out  32      one-hot write enables to register file, registered
//  wr_data     out  64      write data, valid with wr_enables, registered
//  busy_mask   out  32      bit i set if any queued r1 entry targets register i
// BEHAVIOUR
//  Reset (reset=0, async): wr_enables=0, wr_data=0, queue empty, wait_cnt=0,
//   busy_mask=0, r1_ready=1, r0_ready=1.
//  Handshake: a transfer occurs at a rising edge with valid & ready high.
//   Requesters hold addr/data stable while valid and not ready.
//  r1 path: every accepted r1 request is pushed into the queue; r1 never bypasses it.
//   r1_ready = !full, computed from registered state.
//   Push while full is never accepted, even if the same edge pops.
//  Arbitration (per cycle, combinational):
//   force = queue non-empty & wait_cnt == MAX_WAIT.
//   r0_ready = !force.
//   grant_r0 = r0_valid & !force.
//   grant_q  = queue non-empty & !grant_r0 (pop at edge).
//  wait_cnt: 0 when queue empty or head popped; else increments each edge, saturating at MAX_WAIT.
//   A new head starts at 0.
//  Output register at each edge:
//   wr_data = winner data.
//   wr_enables = one-hot(winner addr); all-zero if no winner or winner addr == 31.
//   X31 is the zero register: such requests are still accepted/popped, never written.
//  Latency:
//   r0 accepted at edge E -> enables high in cycle after E -> regfile captures at E+1.
//   r1 pushed at E -> earliest pop at E+1 -> capture at E+2.
//  Ordering: queue is strict FIFO. No ordering between r0 and r1 to the same register;
//   the hazard unit uses busy_mask to prevent it.
//  busy_mask: OR over valid queue entries of one-hot(addr), excluding 31.
//   Combinational from queue state; a popped entry clears the same edge it pops.
//  Simultaneous push+pop with queue not full: both occur, count unchanged.
//  Reset mid-operation: queued requests are discarded; no partial write is issued.
// STRUCTURE
//  regfile_pkg:
//   NUM_REGS=32, REG_W=64, ADDR_W=5, ZERO_REG=31.
//   typedef struct packed {logic [ADDR_W-1:0] addr; logic [REG_W-1:0] data;} wb_req_t.
//   Function onehot_en(addr) returning the 32-bit enable (zero for ZERO_REG).
//  Sub-module wb_fifo (DEPTH, wb_req_t): push/pop/full/empty/head, plus entries + valid bits for busy_mask.
//  Top: arbitration logic, wait_cnt, output register.
// TESTING
//  1. Reset, r0 only: r0 addr=5 data=0xA5 -> wr_enables=32'h20, wr_data=0xA5 one cycle later; r1_ready=1.
//  2. r1 only: addr=2 data=0x11 -> busy_mask=32'h4 for one cycle, then wr_enables=32'h4;
//     busy_mask clears as the pop happens.
//  3. r0_valid held high continuously, one r1 push: r1 loses for MAX_WAIT=3 cycles, then r0_ready=0
//     for one cycle and r1 writes; r0 resumes next cycle.
//  4. Fill queue with 4 r1 requests while r0 busy: r1_ready=0; 5th request held until a pop frees an entry.
//     Drain order matches push order.
//  5. r0 addr=31 and r1 addr=31: both accepted/popped, wr_enables stays 0, busy_mask stays 0.
//  6. Assert reset with 3 queued entries: next cycle wr_enables=0, busy_mask=0, r1_ready=1, no stale write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Holds the request struct and the one-hot enable decode that skips the zero register.
package regfile_wb_arbiter_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 64;
    localparam int ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] onehot_en(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] en;
        en = '0;
        if (addr != ZERO_REG) en[addr] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/response bundle between the two writeback sources and the arbiter.
// master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                    r0_valid;
    logic                    r0_ready;
    logic [ADDR_W-1:0]       r0_addr;
    logic [REG_W-1:0]        r0_data;
    logic                    r1_valid;
    logic                    r1_ready;
    logic [ADDR_W-1:0]       r1_addr;
    logic [REG_W-1:0]        r1_data;
    logic [NUM_REGS-1:0]     wr_enables;
    logic [REG_W-1:0]        wr_data;
    logic [NUM_REGS-1:0]     busy_mask;

    modport master (
        output r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
        input  r0_ready, r1_ready, wr_enables, wr_data, busy_mask
    );

    modport slave (
        input  r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
        output r0_ready, r1_ready, wr_enables, wr_data, busy_mask
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Purpose: strict-FIFO queue of writeback requests, exposing every slot and its valid bit.
// Latency: pushed entry is visible at head the cycle after the push edge.
// Backpressure: push ignored while full (even if popping the same edge); pop ignored while empty.
module regfile_wb_arbiter_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_req_t          push_req,
    input  logic             pop,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output wb_req_t          ent [DEPTH],
    output logic [DEPTH-1:0] ent_vld
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    wb_req_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign ent     = mem;

    // Storage needs no reset: slots are only observed through ent_vld.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (do_push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                ent_vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: share the register-file write port between EX writeback (r0) and queued load returns (r1).
// Latency: r0 accepted at E writes at E+1; r1 pushed at E writes at E+2 at the earliest.
// Backpressure: r1_ready = queue not full; r0_ready drops only while the aged queue head is forced through.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    wb_req_t             q_head;
    wb_req_t             q_ent [DEPTH];
    logic [DEPTH-1:0]    q_vld;
    logic                q_full;
    logic                q_empty;
    logic [WW-1:0]       wait_cnt;
    logic                force_head;
    logic                grant_r0;
    logic                grant_q;
    logic                r1_push;
    wb_req_t             r1_req;
    logic [NUM_REGS-1:0] wr_enables_q;
    logic [REG_W-1:0]    wr_data_q;
    logic [NUM_REGS-1:0] busy_mask_c;

    assign r1_req.addr = bus.r1_addr;
    assign r1_req.data = bus.r1_data;
    assign r1_push     = bus.r1_valid & ~q_full;

    regfile_wb_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (r1_push),
        .push_req (r1_req),
        .pop      (grant_q),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .ent      (q_ent),
        .ent_vld  (q_vld)
    );

    // A head that has lost MAX_WAIT times takes the port unconditionally.
    assign force_head = ~q_empty & (wait_cnt == WW'(MAX_WAIT));
    assign grant_r0   = bus.r0_valid & ~force_head;
    assign grant_q    = ~q_empty & ~grant_r0;

    assign bus.r0_ready = ~force_head;
    assign bus.r1_ready = ~q_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (q_empty || grant_q) begin
            wait_cnt <= '0;
        end else if (!force_head) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_enables_q <= '0;
            wr_data_q    <= '0;
        end else if (grant_r0) begin
            wr_enables_q <= onehot_en(bus.r0_addr);
            wr_data_q    <= bus.r0_data;
        end else if (grant_q) begin
            wr_enables_q <= onehot_en(q_head.addr);
            wr_data_q    <= q_head.data;
        end else begin
            wr_enables_q <= '0;
        end
    end

    always_comb begin
        busy_mask_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i]) busy_mask_c = busy_mask_c | onehot_en(q_ent[i].addr);
        end
    end

    assign bus.wr_enables = wr_enables_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy_mask  = busy_mask_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked cycle by cycle against a queue-based model.
// Purpose: bench only; latency/backpressure are whatever the DUT exposes.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: pending r1 requests in order, and how many edges the head has lost.
    wb_req_t mq[$];
    int      age = 0;
    logic    r0_acc = 1'b1;
    logic    r1_acc = 1'b1;
    int      r0_low_cnt = 0;

    function automatic logic [31:0] ref_en(input logic [4:0] a);
        return (a == 5'd31) ? 32'h0 : (32'h1 << a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_r0(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.r0_valid = v;
        bus.r0_addr  = a;
        bus.r0_data  = d;
    endtask

    task automatic set_r1(input logic v, input logic [4:0] a, input logic [63:0] d);
        bus.r1_valid = v;
        bus.r1_addr  = a;
        bus.r1_data  = d;
    endtask

    // One clock: check combinational outputs, predict the edge, check registered outputs.
    task automatic cycle();
        logic [31:0] exp_busy;
        logic        exp_r0r;
        logic        exp_r1r;
        logic        g0;
        logic        gq;
        logic        pu;
        logic        has_w;
        wb_req_t     w;
        wb_req_t     pr;
        #2;
        exp_busy = 32'h0;
        foreach (mq[i]) exp_busy = exp_busy | ref_en(mq[i].addr);
        exp_r0r = !((mq.size() > 0) && (age == MAX_WAIT));
        exp_r1r = (mq.size() < DEPTH);
        chk("r0_ready", 64'(bus.r0_ready), 64'(exp_r0r));
        chk("r1_ready", 64'(bus.r1_ready), 64'(exp_r1r));
        chk("busy_mask", 64'(bus.busy_mask), 64'(exp_busy));
        if (bus.r0_ready === 1'b0) r0_low_cnt++;
        g0 = bus.r0_valid && exp_r0r;
        gq = (mq.size() > 0) && !g0;
        pu = bus.r1_valid && exp_r1r;
        pr.addr = bus.r1_addr;
        pr.data = bus.r1_data;
        has_w = 1'b1;
        w = '0;
        if (g0) begin
            w.addr = bus.r0_addr;
            w.data = bus.r0_data;
        end else if (gq) begin
            w = mq[0];
        end else begin
            has_w = 1'b0;
        end
        r0_acc = g0;
        r1_acc = pu;
        @(posedge clk);
        #1;
        chk("wr_enables", 64'(bus.wr_enables), has_w ? 64'(ref_en(w.addr)) : 64'h0);
        if (has_w) chk("wr_data", bus.wr_data, w.data);
        if (gq) begin
            void'(mq.pop_front());
            age = 0;
        end else if (mq.size() > 0) begin
            age = (age + 1 > MAX_WAIT) ? MAX_WAIT : age + 1;
        end else begin
            age = 0;
        end
        if (pu) mq.push_back(pr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_r0(1'b0, 5'd0, 64'h0);
        set_r1(1'b0, 5'd0, 64'h0);
        #12;
        chk("rst_wr_enables", 64'(bus.wr_enables), 64'h0);
        chk("rst_wr_data", bus.wr_data, 64'h0);
        chk("rst_busy", 64'(bus.busy_mask), 64'h0);
        chk("rst_r0_ready", 64'(bus.r0_ready), 64'h1);
        chk("rst_r1_ready", 64'(bus.r1_ready), 64'h1);
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // r0 alone
        set_r0(1'b1, 5'd5, 64'hA5);
        cycle();
        chk("t1_en", 64'(bus.wr_enables), 64'h20);
        chk("t1_data", bus.wr_data, 64'hA5);
        set_r0(1'b0, 5'd0, 64'h0);
        cycle();

        // r1 alone
        set_r1(1'b1, 5'd2, 64'h11);
        cycle();
        set_r1(1'b0, 5'd0, 64'h0);
        chk("t2_busy", 64'(bus.busy_mask), 64'h4);
        cycle();
        chk("t2_en", 64'(bus.wr_enables), 64'h4);
        cycle();

        // r0 saturating the port, one r1 push: head must be forced through once
        r0_low_cnt = 0;
        set_r0(1'b1, 5'd7, 64'h700);
        set_r1(1'b1, 5'd9, 64'h900);
        cycle();
        set_r1(1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 7; i++) begin
            bus.r0_data = 64'h701 + 64'(i);
            cycle();
        end
        chk("t3_r0_stall_cycles", 64'(r0_low_cnt), 64'd1);

        // fill the queue while r0 is busy, 5th push must wait
        for (int i = 0; i < 4; i++) begin
            set_r1(1'b1, 5'(10 + i), 64'hB00 + 64'(i));
            cycle();
        end
        set_r1(1'b1, 5'd20, 64'hB04);
        chk("t4_full_ready", 64'(bus.r1_ready), 64'h0);
        begin
            int n = 0;
            do begin
                cycle();
                n++;
            end while (!r1_acc && n < 20);
            chk("t4_fifth_accepted", 64'(r1_acc), 64'h1);
        end
        set_r1(1'b0, 5'd0, 64'h0);
        set_r0(1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 8; i++) cycle();

        // zero register on both sources
        set_r0(1'b1, 5'd31, 64'hDEAD);
        set_r1(1'b1, 5'd31, 64'hBEEF);
        cycle();
        set_r0(1'b0, 5'd0, 64'h0);
        set_r1(1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic honouring the hold-while-not-ready rule
        r0_acc = 1'b1;
        r1_acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(bus.r0_valid && !r0_acc))
                set_r0(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if (!(bus.r1_valid && !r1_acc))
                set_r1(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), {$urandom, $urandom});
            cycle();
        end
        set_r0(1'b0, 5'd0, 64'h0);
        set_r1(1'b0, 5'd0, 64'h0);
        for (int i = 0; i < 10; i++) cycle();

        // reset with three entries queued
        set_r0(1'b1, 5'd1, 64'h100);
        for (int i = 0; i < 3; i++) begin
            set_r1(1'b1, 5'(3 + i), 64'hC00 + 64'(i));
            cycle();
        end
        chk("t6_queued", 64'(mq.size()), 64'd3);
        set_r0(1'b0, 5'd0, 64'h0);
        set_r1(1'b0, 5'd0, 64'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", 64'(bus.wr_enables), 64'h0);
        chk("t6_rst_busy", 64'(bus.busy_mask), 64'h0);
        chk("t6_rst_r1_ready", 64'(bus.r1_ready), 64'h1);
        chk("t6_rst_r0_ready", 64'(bus.r0_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("t6_rst_en_hold", 64'(bus.wr_enables), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        age = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
